keyboard_note_decoder: RTL and testbench

Converts the PS/2 keyboard byte stream (set-2 scancodes, already deserialized) into note events for `ALUcontroller`. It drives `note_in`, `note` and `octave`, plus a gate level for the envelope. It handles make/break prefixes, extended-code suppression, typematic-repeat filtering and an up/down octave register. It sits between the PS/2 receiver and `ALUcontroller`.

---
 rtl/synth_pkg.sv | 49 ++++
 rtl/keyboard_note_decoder_if.sv | 25 ++
 rtl/scancode_to_note.sv | 35 +++
 rtl/keyboard_note_decoder.sv | 140 ++++++++++++++
 tb/tb_keyboard_note_decoder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared constants for the keyboard front end: set-2 scancodes,
// note codes and the prefix-decoder state type.
package synth_pkg;

    localparam int OCT_W  = 3;
    localparam int NOTE_W = 4;

    // Note-key make codes, one per semitone from C upward
    localparam logic [7:0] SC_C    = 8'h1C;
    localparam logic [7:0] SC_CS   = 8'h1D;
    localparam logic [7:0] SC_D    = 8'h1B;
    localparam logic [7:0] SC_DS   = 8'h24;
    localparam logic [7:0] SC_E    = 8'h23;
    localparam logic [7:0] SC_F    = 8'h2B;
    localparam logic [7:0] SC_FS   = 8'h2C;
    localparam logic [7:0] SC_G    = 8'h34;
    localparam logic [7:0] SC_GS   = 8'h35;
    localparam logic [7:0] SC_A    = 8'h33;
    localparam logic [7:0] SC_AS   = 8'h3C;
    localparam logic [7:0] SC_B    = 8'h3B;
    localparam logic [7:0] SC_C_HI = 8'h42;

    // Prefix and octave-control codes
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_OCT_DN = 8'h1A;
    localparam logic [7:0] SC_OCT_UP = 8'h22;

    localparam logic [NOTE_W-1:0] NOTE_C  = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_CS = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_D  = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_DS = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_E  = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_F  = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_FS = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_G  = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_GS = 4'd8;
    localparam logic [NOTE_W-1:0] NOTE_A  = 4'd9;
    localparam logic [NOTE_W-1:0] NOTE_AS = 4'd10;
    localparam logic [NOTE_W-1:0] NOTE_B  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } prefix_state_t;

endpackage

// File: rtl/keyboard_note_decoder_if.sv
// Byte stream from the PS/2 receiver in, note events toward ALUcontroller out.
interface keyboard_note_decoder_if;
    import synth_pkg::*;

    logic [7:0]        ps2_byte;
    logic              ps2_valid;
    logic              note_in;
    logic [NOTE_W-1:0] note;
    logic [OCT_W-1:0]  octave;
    logic              gate;
    logic              note_off;

    // Byte source / note consumer side
    modport master (
        output ps2_byte, ps2_valid,
        input  note_in, note, octave, gate, note_off
    );

    // Decoder side
    modport slave (
        input  ps2_byte, ps2_valid,
        output note_in, note, octave, gate, note_off
    );

endinterface

// File: rtl/scancode_to_note.sv
// Combinational map from a set-2 make code to a note number; 42 is the
// C one octave above the others.
module scancode_to_note
    import synth_pkg::*;
(
    input  logic [7:0]        code,
    output logic              is_note,
    output logic [NOTE_W-1:0] note,
    output logic              oct_plus1
);

    // Table lookup; unmapped codes report is_note = 0
    always_comb begin
        is_note   = 1'b1;
        note      = NOTE_C;
        oct_plus1 = 1'b0;
        case (code)
            SC_C:    note = NOTE_C;
            SC_CS:   note = NOTE_CS;
            SC_D:    note = NOTE_D;
            SC_DS:   note = NOTE_DS;
            SC_E:    note = NOTE_E;
            SC_F:    note = NOTE_F;
            SC_FS:   note = NOTE_FS;
            SC_G:    note = NOTE_G;
            SC_GS:   note = NOTE_GS;
            SC_A:    note = NOTE_A;
            SC_AS:   note = NOTE_AS;
            SC_B:    note = NOTE_B;
            SC_C_HI: oct_plus1 = 1'b1;
            default: is_note = 1'b0;
        endcase
    end

endmodule

// File: rtl/keyboard_note_decoder.sv
// Turns the PS/2 scancode stream into note_in / gate / note_off events with
// last-note priority, typematic filtering and a saturating octave register.
module keyboard_note_decoder
    import synth_pkg::*;
#(
    parameter int OCT_DEFAULT = 4,
    parameter int OCT_MAX     = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    keyboard_note_decoder_if.slave  bus
);

    localparam logic [OCT_W-1:0] OCT_DEF_V = OCT_W'(OCT_DEFAULT);
    localparam logic [OCT_W-1:0] OCT_MAX_V = OCT_W'(OCT_MAX);
    localparam logic [OCT_W-1:0] OCT_ONE   = OCT_W'(1);

    prefix_state_t     state_q, state_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [OCT_W-1:0]  octave_q, octave_d;
    logic [OCT_W-1:0]  oct_reg_q, oct_reg_d;
    logic [7:0]        held_code_q, held_code_d;
    logic              note_in_q, note_in_d;
    logic              note_off_q, note_off_d;
    logic              gate_q, gate_d;
    logic              oct_dn_held_q, oct_dn_held_d;
    logic              oct_up_held_q, oct_up_held_d;

    logic              lk_is_note;
    logic [NOTE_W-1:0] lk_note;
    logic              lk_oct_plus1;
    logic              hi_c_blocked;

    scancode_to_note u_lookup (
        .code      (bus.ps2_byte),
        .is_note   (lk_is_note),
        .note      (lk_note),
        .oct_plus1 (lk_oct_plus1)
    );

    // The upper C has no octave above the top one to land in
    assign hi_c_blocked = lk_oct_plus1 && (oct_reg_q == OCT_MAX_V);

    // Prefix FSM plus make/break actions; one byte consumed per strobe
    always_comb begin
        state_d       = state_q;
        note_d        = note_q;
        octave_d      = octave_q;
        oct_reg_d     = oct_reg_q;
        held_code_d   = held_code_q;
        gate_d        = gate_q;
        oct_dn_held_d = oct_dn_held_q;
        oct_up_held_d = oct_up_held_q;
        note_in_d     = 1'b0;
        note_off_d    = 1'b0;
        if (bus.ps2_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ps2_byte == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (bus.ps2_byte == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (bus.ps2_byte == SC_OCT_DN) begin
                        if (!oct_dn_held_q) begin
                            oct_dn_held_d = 1'b1;
                            if (oct_reg_q != '0) oct_reg_d = oct_reg_q - OCT_ONE;
                        end
                    end else if (bus.ps2_byte == SC_OCT_UP) begin
                        if (!oct_up_held_q) begin
                            oct_up_held_d = 1'b1;
                            if (oct_reg_q != OCT_MAX_V) oct_reg_d = oct_reg_q + OCT_ONE;
                        end
                    end else if (lk_is_note && !hi_c_blocked &&
                                 bus.ps2_byte != held_code_q) begin
                        note_d      = lk_note;
                        octave_d    = oct_reg_q + {{(OCT_W-1){1'b0}}, lk_oct_plus1};
                        held_code_d = bus.ps2_byte;
                        gate_d      = 1'b1;
                        note_in_d   = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    if (bus.ps2_byte == SC_OCT_DN) begin
                        oct_dn_held_d = 1'b0;
                    end else if (bus.ps2_byte == SC_OCT_UP) begin
                        oct_up_held_d = 1'b0;
                    end else if (lk_is_note && bus.ps2_byte == held_code_q) begin
                        gate_d      = 1'b0;
                        note_off_d  = 1'b1;
                        held_code_d = 8'h00;
                    end
                end
                ST_EXT: begin
                    state_d = (bus.ps2_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            note_q        <= NOTE_C;
            octave_q      <= OCT_DEF_V;
            oct_reg_q     <= OCT_DEF_V;
            held_code_q   <= 8'h00;
            gate_q        <= 1'b0;
            note_in_q     <= 1'b0;
            note_off_q    <= 1'b0;
            oct_dn_held_q <= 1'b0;
            oct_up_held_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            note_q        <= note_d;
            octave_q      <= octave_d;
            oct_reg_q     <= oct_reg_d;
            held_code_q   <= held_code_d;
            gate_q        <= gate_d;
            note_in_q     <= note_in_d;
            note_off_q    <= note_off_d;
            oct_dn_held_q <= oct_dn_held_d;
            oct_up_held_q <= oct_up_held_d;
        end
    end

    assign bus.note_in  = note_in_q;
    assign bus.note     = note_q;
    assign bus.octave   = octave_q;
    assign bus.gate     = gate_q;
    assign bus.note_off = note_off_q;

endmodule

// File: tb/tb_keyboard_note_decoder.sv
// Bench for keyboard_note_decoder: directed walk through the main scenarios,
// then random byte streams against a sequence-level reference model.
module tb_keyboard_note_decoder;

    localparam int OCT_DEFAULT = 4;
    localparam int OCT_MAX     = 6;

    logic clk = 1'b0;
    logic reset;

    keyboard_note_decoder_if kif ();

    keyboard_note_decoder #(
        .OCT_DEFAULT (OCT_DEFAULT),
        .OCT_MAX     (OCT_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (kif.slave)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int noteInCount = 0;

    // Reference model: bytes collect in a queue until they form a complete
    // key sequence, which is then interpreted as a whole.
    logic [7:0] noteCodes [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                   8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
    logic [7:0] pend [$];
    int         mOctReg;
    logic [7:0] mHeld;
    bit         mUpHeld, mDnHeld;
    int         mNote, mOctave;
    bit         mGate, mNoteIn, mNoteOff;

    function automatic int keyIndex(input logic [7:0] c);
        for (int i = 0; i < 12; i++) if (noteCodes[i] == c) return i;
        if (c == 8'h42) return 12;
        return -1;
    endfunction

    task automatic modelReset();
        pend.delete();
        mOctReg = OCT_DEFAULT; mHeld = 8'h00; mUpHeld = 0; mDnHeld = 0;
        mNote = 0; mOctave = OCT_DEFAULT; mGate = 0; mNoteIn = 0; mNoteOff = 0;
    endtask

    task automatic keyMake(input logic [7:0] c);
        int idx;
        idx = keyIndex(c);
        if (c == 8'h1A) begin
            if (!mDnHeld) begin mDnHeld = 1; if (mOctReg > 0) mOctReg--; end
        end else if (c == 8'h22) begin
            if (!mUpHeld) begin mUpHeld = 1; if (mOctReg < OCT_MAX) mOctReg++; end
        end else if (idx >= 0) begin
            if (idx == 12 && mOctReg == OCT_MAX) return;
            if (c == mHeld) return;
            mNote   = idx % 12;
            mOctave = mOctReg + (idx == 12 ? 1 : 0);
            mHeld   = c;
            mGate   = 1;
            mNoteIn = 1;
        end
    endtask

    task automatic keyBreak(input logic [7:0] c);
        if (c == 8'h1A) mDnHeld = 0;
        else if (c == 8'h22) mUpHeld = 0;
        else if (keyIndex(c) >= 0 && c == mHeld) begin
            mGate = 0; mNoteOff = 1; mHeld = 8'h00;
        end
    endtask

    task automatic modelByte(input logic [7:0] b);
        pend.push_back(b);
        if (pend[0] == 8'hF0) begin
            if (pend.size() == 2) begin keyBreak(pend[1]); pend.delete(); end
        end else if (pend[0] == 8'hE0) begin
            if ((pend.size() == 2 && pend[1] != 8'hF0) || pend.size() == 3) pend.delete();
        end else begin
            keyMake(pend[0]);
            pend.delete();
        end
    endtask

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("note_in",  32'(kif.note_in),  32'(mNoteIn));
        checkOutput("note_off", 32'(kif.note_off), 32'(mNoteOff));
        checkOutput("gate",     32'(kif.gate),     32'(mGate));
        checkOutput("note",     32'(kif.note),     32'(mNote));
        checkOutput("octave",   32'(kif.octave),   32'(mOctave));
    endtask

    // Drives one cycle of input, advances the model and compares everything
    task automatic applyStimulus(input logic [7:0] b, input logic v);
        @(negedge clk);
        kif.ps2_byte  = b;
        kif.ps2_valid = v;
        @(posedge clk);
        #1;
        mNoteIn = 0; mNoteOff = 0;
        if (v) modelByte(b);
        if (kif.note_in) noteInCount++;
        checkAll();
    endtask

    task automatic applyReset(input logic [7:0] b, input logic v);
        @(negedge clk);
        reset         = 1'b0;
        kif.ps2_byte  = b;
        kif.ps2_valid = v;
        @(posedge clk);
        #1;
        modelReset();
        checkAll();
        reset         = 1'b1;
        kif.ps2_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        applyStimulus(b, 1'b1);
    endtask

    initial begin
        logic [7:0] b;
        int r;
        reset = 1'b0;
        kif.ps2_byte = 8'h00;
        kif.ps2_valid = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);

        // Reset values
        applyReset(8'h00, 1'b0);
        checkOutput("rst_octave", 32'(kif.octave), 32'(OCT_DEFAULT));
        checkOutput("rst_gate", 32'(kif.gate), 0);

        // Basic make/break
        send(8'h1C);
        checkOutput("make_c_note_in", 32'(kif.note_in), 1);
        checkOutput("make_c_octave", 32'(kif.octave), 4);
        checkOutput("make_c_gate", 32'(kif.gate), 1);
        send(8'hF0); send(8'h1C);
        checkOutput("brk_c_note_off", 32'(kif.note_off), 1);
        checkOutput("brk_c_gate", 32'(kif.gate), 0);

        // Typematic repeat and last-note priority
        noteInCount = 0;
        send(8'h1C); send(8'h1C); send(8'h1C);
        checkOutput("repeat_one_pulse", 32'(noteInCount), 1);
        send(8'h33);
        checkOutput("prio_note", 32'(kif.note), 9);
        checkOutput("prio_gate", 32'(kif.gate), 1);
        send(8'hF0); send(8'h1C);
        checkOutput("stale_brk_no_off", 32'(kif.note_off), 0);
        send(8'hF0); send(8'h33);
        checkOutput("held_brk_off", 32'(kif.note_off), 1);

        // Octave up to saturation, blocked upper C
        repeat (4) begin send(8'h22); send(8'hF0); send(8'h22); end
        send(8'h42);
        checkOutput("hi_c_blocked", 32'(kif.note_in), 0);
        send(8'h3B);
        checkOutput("top_b_note", 32'(kif.note), 11);
        checkOutput("top_b_octave", 32'(kif.octave), 6);
        send(8'hF0); send(8'h3B);

        // Held octave key, down step, upper C
        applyReset(8'h00, 1'b0);
        send(8'h22); send(8'h22); send(8'hF0); send(8'h22); send(8'h1A);
        send(8'h42);
        checkOutput("hi_c_note", 32'(kif.note), 0);
        checkOutput("hi_c_octave", 32'(kif.octave), 5);
        send(8'hF0); send(8'h1A); send(8'hF0); send(8'h42);

        // Extended keys are swallowed
        send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C);
        checkOutput("ext_gate", 32'(kif.gate), 0);
        send(8'h1C);
        checkOutput("after_ext_note_in", 32'(kif.note_in), 1);
        send(8'hF0); send(8'h1C);

        // Reset mid-break, then back-to-back strobes
        send(8'hF0);
        applyReset(8'h1C, 1'b1);
        send(8'h1C);
        checkOutput("post_rst_make", 32'(kif.note_in), 1);
        send(8'hF0); send(8'h1C);
        send(8'h1C);
        checkOutput("b2b_note_in", 32'(kif.note_in), 1);
        send(8'hF0);
        send(8'h1C);
        checkOutput("b2b_note_off", 32'(kif.note_off), 1);

        // Random streams biased toward meaningful codes
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                applyReset(8'($urandom), 1'($urandom));
                continue;
            end
            r = $urandom_range(0, 15);
            case (r)
                0, 1, 2, 3, 4, 5: b = noteCodes[$urandom_range(0, 11)];
                6:       b = 8'h42;
                7:       b = 8'h1A;
                8:       b = 8'h22;
                9, 10:   b = 8'hF0;
                11:      b = 8'hE0;
                12:      b = 8'($urandom);
                15:      b = (mHeld != 8'h00) ? mHeld : 8'h1C;
                default: b = 8'h00;
            endcase
            applyStimulus(b, (r == 13 || r == 14) ? 1'b0 : 1'b1);
        end

        @(negedge clk);
        kif.ps2_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
